// File: rtl/pc_sequencer.sv
// Program-counter register stage: fetch address, run/done status and a saturating retired-instruction count.
// Optional return stack enabled by defining RET_STACK_EN.
module pc_sequencer #(
    parameter int D           = 12,
    parameter int START_ADDR  = 0,
    parameter int CNT_W       = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                start,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic signed [D-1:0] target,
    input  logic                halt_req,
    input  logic                call_en,
    input  logic                ret_en,
    output logic [D-1:0]        prog_counter,
    output logic                running,
    output logic                done,
    output logic [CNT_W-1:0]    instr_count,
    output logic                stack_err
);

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    localparam logic [D-1:0] START_PC = D'(START_ADDR);

    if (START_ADDR < 0 || longint'(START_ADDR) >= (longint'(1) << D) || STACK_DEPTH < 1) begin : g_bad_params
        $error("pc_sequencer: START_ADDR must fit in D bits and STACK_DEPTH must be at least 1");
    end

    state_t         state;
    logic [D-1:0]   pc_inc;
    logic [D-1:0]   pc_rel;

    // Target is two's complement, so an unsigned D-bit add gives the signed offset modulo 2^D.
    assign pc_inc = prog_counter + D'(1);
    assign pc_rel = prog_counter + $unsigned(target);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

`ifdef RET_STACK_EN
    localparam int              SP_W    = $clog2(STACK_DEPTH + 1);
    localparam int              IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    logic [D-1:0]    stack_mem [STACK_DEPTH];
    logic [SP_W-1:0] sp;
    logic            stack_err_q;
    logic            op_active;
    logic            push_en;
    logic [D-1:0]    top_entry;

    assign stack_err = stack_err_q;
    assign op_active = (state == RUN) && !start && !stall && !halt_req;
    assign push_en   = op_active && !ret_en && call_en && (sp != SP_FULL);
    assign top_entry = stack_mem[IDX_W'(sp - 1'b1)];

    // Stack storage is pure data and carries no reset; sp alone defines validity.
    always_ff @(posedge Clk) begin
        if (push_en) begin
            stack_mem[IDX_W'(sp)] <= pc_inc;
        end
    end
`else
    assign stack_err = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            prog_counter <= START_PC;
            running      <= 1'b0;
            done         <= 1'b0;
            instr_count  <= '0;
`ifdef RET_STACK_EN
            sp           <= '0;
            stack_err_q  <= 1'b0;
`endif
        end else if (start) begin
            // start behaves identically from IDLE, RUN and HALTED
            state        <= RUN;
            running      <= 1'b1;
            done         <= 1'b0;
            prog_counter <= START_PC;
            instr_count  <= '0;
`ifdef RET_STACK_EN
            sp           <= '0;
            stack_err_q  <= 1'b0;
`endif
        end else if (state == RUN && !stall) begin
            instr_count <= sat_inc(instr_count);
            if (halt_req) begin
                state   <= HALTED;
                running <= 1'b0;
                done    <= 1'b1;
            end
`ifdef RET_STACK_EN
            else if (ret_en) begin
                if (sp == '0) begin
                    prog_counter <= pc_inc;
                    stack_err_q  <= 1'b1;
                end else begin
                    prog_counter <= top_entry;
                    sp           <= sp - 1'b1;
                end
            end else if (call_en) begin
                prog_counter <= pc_rel;
                if (sp == SP_FULL) begin
                    stack_err_q <= 1'b1;
                end else begin
                    sp <= sp + 1'b1;
                end
            end
`else
            else if (ret_en) begin
                prog_counter <= pc_inc;
            end else if (call_en) begin
                prog_counter <= pc_rel;
            end
`endif
            else if (branch_taken) begin
                prog_counter <= pc_rel;
            end else begin
                prog_counter <= pc_inc;
            end
        end
    end

endmodule
